// File: rtl/sccb_arbiter.sv
// Round-robin arbiter that shares one SCCB/I2C transfer engine among NREQ requesters.
// Each grant runs one engine transfer with NACK retries and a per-wait-state timeout.
module sccb_arbiter #(
    parameter int NREQ      = 3,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 1000000
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [NREQ-1:0]      iREQ,
    input  logic [24*NREQ-1:0]   iDATA,
    output logic [NREQ-1:0]      oGNT,
    output logic [NREQ-1:0]      oDONE,
    output logic [NREQ-1:0]      oERR,
    output logic                 oBUSY,
    output logic [23:0]          oI2C_DATA,
    output logic                 oI2C_GO,
    input  logic                 iI2C_END,
    input  logic                 iI2C_ACK
);
    localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [19:0]     TMO_LAST = 20'(TIMEOUT - 1);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, XFER, REL, DONE} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [23:0]     data_q, data_d;
    logic            go_q, go_d;
    logic [7:0]      retry_q, retry_d;
    logic [19:0]     tmo_q, tmo_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic            rtry_q, rtry_d;
    logic            fail_q, fail_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic [23:0]     pick_data;
    logic            tmo_hit;

    assign tmo_hit = (tmo_q == TMO_LAST);

    // Search starts just after the last winner, so a repeat requester goes to the back.
    always_comb begin
        pick_vld  = 1'b0;
        pick_idx  = last_q;
        cand      = last_q;
        pick_data = 24'h000000;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!pick_vld && iREQ[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) pick_data = iDATA[24*i +: 24];
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        data_d  = data_q;
        go_d    = go_q;
        retry_d = retry_q;
        tmo_d   = tmo_q;
        last_d  = last_q;
        sel_d   = sel_q;
        rtry_d  = rtry_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick_idx;
                    gnt_d   = ONE << pick_idx;
                    data_d  = pick_data;
                    go_d    = 1'b1;
                    retry_d = '0;
                    tmo_d   = '0;
                    rtry_d  = 1'b0;
                    fail_d  = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                tmo_d = tmo_q + 20'd1;
                if (tmo_hit) begin
                    go_d    = 1'b0;
                    fail_d  = 1'b1;
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    state_d = DONE;
                end else if (iI2C_END) begin
                    go_d    = 1'b0;
                    tmo_d   = '0;
                    state_d = REL;
                    if (!iI2C_ACK) begin
                        rtry_d = 1'b0;
                        fail_d = 1'b0;
                    end else if (int'(retry_q) < MAX_RETRY) begin
                        rtry_d = 1'b1;
                    end else begin
                        rtry_d = 1'b0;
                        fail_d = 1'b1;
                    end
                end
            end
            REL: begin
                tmo_d = tmo_q + 20'd1;
                if (tmo_hit) begin
                    go_d    = 1'b0;
                    fail_d  = 1'b1;
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    state_d = DONE;
                end else if (!iI2C_END) begin
                    if (rtry_q) begin
                        retry_d = retry_q + 8'd1;
                        go_d    = 1'b1;
                        tmo_d   = '0;
                        rtry_d  = 1'b0;
                        state_d = XFER;
                    end else begin
                        done_d  = gnt_q;
                        err_d   = fail_q ? gnt_q : '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                gnt_d   = '0;
                last_d  = sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            data_q  <= 24'h000000;
            go_q    <= 1'b0;
            retry_q <= '0;
            tmo_q   <= '0;
            last_q  <= LAST_RST;
            sel_q   <= '0;
            rtry_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            data_q  <= data_d;
            go_q    <= go_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            rtry_q  <= rtry_d;
            fail_q  <= fail_d;
        end
    end

    assign oGNT      = gnt_q;
    assign oDONE     = done_q;
    assign oERR      = err_q;
    assign oBUSY     = (state_q != IDLE);
    assign oI2C_DATA = data_q;
    assign oI2C_GO   = go_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Bench for sccb_arbiter: a behavioural engine model plus a scoreboard of expected
// completions (requester, data word, error) checked whenever oDONE pulses.
module tb_sccb_arbiter;
    localparam int NREQ = 3;

    logic                iCLK = 1'b0;
    logic                iRST;
    logic [NREQ-1:0]     iREQ;
    logic [24*NREQ-1:0]  iDATA;
    logic [NREQ-1:0]     oGNT, oDONE, oERR;
    logic                oBUSY;
    logic [23:0]         oI2C_DATA;
    logic                oI2C_GO;
    logic                iI2C_END;
    logic                iI2C_ACK;

    sccb_arbiter #(.NREQ(NREQ), .MAX_RETRY(2), .TIMEOUT(100)) dut (
        .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iDATA(iDATA),
        .oGNT(oGNT), .oDONE(oDONE), .oERR(oERR), .oBUSY(oBUSY),
        .oI2C_DATA(oI2C_DATA), .oI2C_GO(oI2C_GO),
        .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int          idx;
        logic [23:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_seen = 0;
    int   go_rises = 0;
    int   eng_delay = 50;
    bit   eng_never = 1'b0;
    bit   eng_nack  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int idx, input logic [23:0] data, input bit err);
        exp_t e;
        e.idx = idx; e.data = data; e.err = err;
        return e;
    endfunction

    // Engine model: END rises eng_delay cycles after GO, falls once GO has dropped.
    initial begin
        int cnt;
        cnt = 0;
        iI2C_END = 1'b0;
        iI2C_ACK = 1'b0;
        forever begin
            @(negedge iCLK);
            if (iI2C_END) begin
                if (!oI2C_GO) begin
                    iI2C_END = 1'b0;
                    iI2C_ACK = 1'b0;
                end
            end else if (oI2C_GO && !eng_never) begin
                cnt++;
                if (cnt >= eng_delay) begin
                    cnt = 0;
                    iI2C_END = 1'b1;
                    iI2C_ACK = eng_nack;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        logic go_prev;
        go_prev = 1'b0;
        forever begin
            @(negedge iCLK);
            if (oI2C_GO && !go_prev) go_rises++;
            go_prev = oI2C_GO;
        end
    end

    // Scoreboard: every completion pulse must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge iCLK);
            if (oDONE != '0) begin
                done_seen++;
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_val("sb_done", 32'(oDONE), 32'(3'b001 << e.idx));
                    check_val("sb_err", 32'(oERR), e.err ? 32'(3'b001 << e.idx) : 32'd0);
                    check_val("sb_data", 32'(oI2C_DATA), 32'(e.data));
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(posedge iCLK); #1;
            if (oDONE != '0) ok = 1'b1;
        end
        check_val(tag, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRST = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        iRST = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] rr_exp [4];
        int base;
        bit seen;
        iRST  = 1'b1;
        iREQ  = '0;
        iDATA = '0;
        do_reset();
        check_val("rst_gnt", 32'(oGNT), 32'd0);
        check_val("rst_done", 32'(oDONE), 32'd0);
        check_val("rst_err", 32'(oERR), 32'd0);
        check_val("rst_busy", 32'(oBUSY), 32'd0);
        check_val("rst_go", 32'(oI2C_GO), 32'd0);
        check_val("rst_data", 32'(oI2C_DATA), 32'd0);

        // Single ACKed transfer from requester 0.
        @(negedge iCLK);
        iDATA[23:0] = 24'h423A04;
        iREQ = 3'b001;
        sb.push_back(mk(0, 24'h423A04, 1'b0));
        @(posedge iCLK); #1;
        check_val("t1_gnt", 32'(oGNT), 32'h1);
        check_val("t1_data", 32'(oI2C_DATA), 32'h423A04);
        check_val("t1_go", 32'(oI2C_GO), 32'd1);
        check_val("t1_busy", 32'(oBUSY), 32'd1);
        iREQ = '0;
        seen = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge iCLK);
            seen = iI2C_END;
        end
        check_val("t1_end_seen", 32'(seen), 32'd1);
        check_val("t1_go_at_end", 32'(oI2C_GO), 32'd1);
        @(posedge iCLK); #1;
        check_val("t1_go_fall", 32'(oI2C_GO), 32'd0);
        @(posedge iCLK); #1;
        check_val("t1_done", 32'(oDONE), 32'h1);
        check_val("t1_err", 32'(oERR), 32'd0);
        @(posedge iCLK); #1;
        check_val("t1_done_1cyc", 32'(oDONE), 32'd0);
        check_val("t1_idle", 32'(oBUSY), 32'd0);

        // All three requesting from reset: round-robin 0,1,2,0 with one IDLE gap.
        eng_delay = 5;
        do_reset();
        @(negedge iCLK);
        iDATA = {24'hC2_0003, 24'hB1_0002, 24'hA0_0001};
        iREQ  = 3'b111;
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
        sb.push_back(mk(0, 24'hA00001, 1'b0));
        sb.push_back(mk(1, 24'hB10002, 1'b0));
        sb.push_back(mk(2, 24'hC20003, 1'b0));
        sb.push_back(mk(0, 24'hA00001, 1'b0));
        @(posedge iCLK); #1;
        check_val("rr_gnt0", 32'(oGNT), 32'(rr_exp[0]));
        for (int t = 0; t < 4; t++) begin
            wait_done("rr_done_seen");
            if (t == 3) iREQ = '0;
            @(posedge iCLK); #1;
            check_val("rr_idle_gnt", 32'(oGNT), 32'd0);
            check_val("rr_idle_busy", 32'(oBUSY), 32'd0);
            if (t < 3) begin
                @(posedge iCLK); #1;
                check_val("rr_gnt", 32'(oGNT), 32'(rr_exp[t+1]));
            end
        end

        // Every attempt NACKed: three GO pulses, then DONE and ERR together.
        eng_nack = 1'b1;
        base = go_rises;
        @(negedge iCLK);
        iDATA[47:24] = 24'h5A_1234;
        iREQ = 3'b010;
        sb.push_back(mk(1, 24'h5A1234, 1'b1));
        @(posedge iCLK); #1;
        check_val("nack_gnt", 32'(oGNT), 32'h2);
        iREQ = '0;
        wait_done("nack_done_seen");
        check_val("nack_done", 32'(oDONE), 32'h2);
        check_val("nack_err", 32'(oERR), 32'h2);
        check_val("nack_go_rises", 32'(go_rises - base), 32'd3);
        eng_nack = 1'b0;
        @(posedge iCLK); #1;

        // Engine never ends: timeout exactly 100 cycles after grant.
        eng_never = 1'b1;
        @(negedge iCLK);
        iDATA[71:48] = 24'h77_0F0F;
        iREQ = 3'b100;
        sb.push_back(mk(2, 24'h770F0F, 1'b1));
        @(posedge iCLK); #1;
        check_val("tmo_gnt", 32'(oGNT), 32'h4);
        iREQ = '0;
        repeat (99) @(posedge iCLK);
        #1;
        check_val("tmo_go_99", 32'(oI2C_GO), 32'd1);
        check_val("tmo_done_99", 32'(oDONE), 32'd0);
        @(posedge iCLK); #1;
        check_val("tmo_go_100", 32'(oI2C_GO), 32'd0);
        check_val("tmo_done", 32'(oDONE), 32'h4);
        check_val("tmo_err", 32'(oERR), 32'h4);
        @(posedge iCLK); #1;
        check_val("tmo_idle", 32'(oBUSY), 32'd0);
        eng_never = 1'b0;
        eng_delay = 50;

        // Reset 10 cycles into a transfer: outputs clear, no completion, requester 2 wins next.
        @(negedge iCLK);
        iDATA[47:24] = 24'h11_2233;
        iREQ = 3'b010;
        @(posedge iCLK); #1;
        check_val("rst_mid_gnt", 32'(oGNT), 32'h2);
        iREQ = '0;
        base = done_seen;
        repeat (9) @(posedge iCLK);
        #1;
        iRST = 1'b1;
        @(posedge iCLK); #1;
        iRST = 1'b0;
        check_val("rst_mid_gnt0", 32'(oGNT), 32'd0);
        check_val("rst_mid_busy", 32'(oBUSY), 32'd0);
        check_val("rst_mid_go", 32'(oI2C_GO), 32'd0);
        check_val("rst_mid_data", 32'(oI2C_DATA), 32'd0);
        check_val("rst_mid_done", 32'(oDONE), 32'd0);
        iDATA[71:48] = 24'h99_8877;
        iREQ = 3'b100;
        sb.push_back(mk(2, 24'h998877, 1'b0));
        @(posedge iCLK); #1;
        check_val("rst_after_gnt", 32'(oGNT), 32'h4);
        iREQ = '0;
        repeat (3) @(posedge iCLK);
        #1;
        check_val("rst_no_done", 32'(done_seen - base), 32'd0);
        wait_done("rst_after_done_seen");

        // Requester 0 drops iREQ and changes iDATA mid-transfer.
        @(posedge iCLK); #1;
        iDATA[23:0] = 24'h3C_5A96;
        iREQ = 3'b001;
        sb.push_back(mk(0, 24'h3C5A96, 1'b0));
        @(posedge iCLK); #1;
        check_val("drop_gnt", 32'(oGNT), 32'h1);
        repeat (5) @(posedge iCLK);
        #1;
        iREQ = '0;
        iDATA[23:0] = 24'hFF_FFFF;
        @(posedge iCLK); #1;
        check_val("drop_data_hold", 32'(oI2C_DATA), 32'h3C5A96);
        wait_done("drop_done_seen");
        check_val("drop_done", 32'(oDONE), 32'h1);

        @(posedge iCLK); #1;
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
